pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage pipeline. Combines the ID-stage hazard decision, ID-stage branch resolution and the MEM-stage multi-cycle memory handshake into one prioritized set of freeze/flush/bubble controls for the PC, IF/ID and ID/EXE registers. Adds a memory-wait watchdog and saturating performance counters. Sits beside the hazard detection unit and drives every pipeline-register enable in the core.

---
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges the ID-stage hazard stall, the ID-stage branch flush and the MEM-stage
// multi-cycle handshake into one prioritized set of pipeline-register controls.
// It also runs a memory-wait watchdog and keeps saturating performance counters.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic [8:0] wait_inc;
  logic       mem_stall;

  // A memory stall only counts while the watchdog has not fired.
  always_comb begin
    mem_stall = mem_req & ~mem_ready & (state != TIMEOUT);
  end

  // State, wait counter, sticky watchdog flag and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mem_timeout <= (state_next == TIMEOUT);
      if (freeze_pc && (state != TIMEOUT) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_if_id && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Next-state and wait-count sequencing of the memory handshake.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    wait_inc      = {1'b0, wait_cnt} + 9'd1;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_inc == 9'(MEM_TIMEOUT)) begin
          state_next = TIMEOUT;
        end else begin
          wait_cnt_next = wait_inc[7:0];
        end
      end
      TIMEOUT: begin
        state_next = TIMEOUT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Prioritized control outputs: watchdog/memory freeze, hazard, branch.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    freeze_pipe   = 1'b0;
    if (!rst) begin
      if ((state == TIMEOUT) || mem_stall) begin
        freeze_pipe  = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
      end else if (hazard_detected) begin
        freeze_pc     = 1'b1;
        freeze_if_id  = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (br_taken) begin
        flush_if_id = 1'b1;
      end
    end
  end

endmodule
